// File: rtl/rs_alloc_unit_if.sv
// Dispatch/issue port bundle for the reservation-station allocator.
// The dispatch side drives requests and issue frees; the allocator answers with grants and occupancy.
interface rs_alloc_unit_if #(
  parameter int RS_ENT_NUM = 2,
  parameter int RS_ENT_SEL = 1
);
  localparam int CNT_W = $clog2(RS_ENT_NUM + 1);

  // Grant handshake: i_dp_req acts as valid. o_alloc_ok acts as ready for the whole request.
  // A slot is transferred in any cycle where o_alloc_vld[k] is high; there is no partial grant and no wait state.
  logic [1:0]            i_dp_req;
  logic                  i_issue_vld;
  logic [RS_ENT_SEL-1:0] i_issue_sel;
  logic                  i_flush;
  logic                  o_alloc_ok;
  logic [1:0]            o_alloc_vld;
  logic [RS_ENT_SEL-1:0] o_alloc_ent0;
  logic [RS_ENT_SEL-1:0] o_alloc_ent1;
  logic [RS_ENT_NUM-1:0] o_busy_vec;
  logic [CNT_W-1:0]      o_free_cnt;

  modport master (
    output i_dp_req, i_issue_vld, i_issue_sel, i_flush,
    input  o_alloc_ok, o_alloc_vld, o_alloc_ent0, o_alloc_ent1, o_busy_vec, o_free_cnt
  );

  modport slave (
    input  i_dp_req, i_issue_vld, i_issue_sel, i_flush,
    output o_alloc_ok, o_alloc_vld, o_alloc_ent0, o_alloc_ent1, o_busy_vec, o_free_cnt
  );
endinterface

// File: rtl/rs_alloc_unit.sv
// Two-wide in-order reservation-station entry allocator.
// The busy vector is the only state; grants come combinationally from the registered busy vector.
module rs_alloc_unit #(
  parameter int RS_ENT_NUM = 2,
  parameter int RS_ENT_SEL = 1
) (
  input  logic clk,
  input  logic reset,
  rs_alloc_unit_if.slave bus
);
  localparam int CNT_W = $clog2(RS_ENT_NUM + 1);

  logic [RS_ENT_NUM-1:0] busy;
  logic [RS_ENT_NUM-1:0] busy_next;
  logic [RS_ENT_NUM-1:0] alloc_mask;
  logic [RS_ENT_NUM-1:0] issue_mask;
  logic [1:0]            req_eff;
  logic [1:0]            req_cnt;
  logic [1:0]            alloc_vld;
  logic                  alloc_ok;
  logic [CNT_W-1:0]      free_cnt;
  logic [RS_ENT_SEL-1:0] ent0;
  logic [RS_ENT_SEL-1:0] ent1;
  logic                  found0;
  logic                  found1;

  // An out-of-order request (younger only) is widened to both slots.
  always_comb begin
    req_eff = (bus.i_dp_req == 2'b10) ? 2'b11 : bus.i_dp_req;
    req_cnt = {1'b0, req_eff[0]} + {1'b0, req_eff[1]};
  end

  always_comb begin
    free_cnt = '0;
    ent0     = '0;
    ent1     = '0;
    found0   = 1'b0;
    found1   = 1'b0;
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      if (!busy[i]) begin
        free_cnt = free_cnt + CNT_W'(1);
        if (!found0) begin
          ent0   = RS_ENT_SEL'(i);
          found0 = 1'b1;
        end else if (!found1) begin
          ent1   = RS_ENT_SEL'(i);
          found1 = 1'b1;
        end
      end
    end
  end

  always_comb begin
    alloc_ok  = (CNT_W'(req_cnt) <= free_cnt) && !bus.i_flush;
    alloc_vld = req_eff & {2{alloc_ok}};
  end

  // Issue only clears entries busy before this edge, so a same-cycle grant to that index survives.
  always_comb begin
    alloc_mask = '0;
    issue_mask = '0;
    for (int i = 0; i < RS_ENT_NUM; i++) begin
      if (alloc_vld[0] && (ent0 == RS_ENT_SEL'(i))) alloc_mask[i] = 1'b1;
      if (alloc_vld[1] && (ent1 == RS_ENT_SEL'(i))) alloc_mask[i] = 1'b1;
      if (bus.i_issue_vld && (bus.i_issue_sel == RS_ENT_SEL'(i))) issue_mask[i] = 1'b1;
    end
    busy_next = bus.i_flush ? '0 : ((busy | alloc_mask) & ~(issue_mask & busy));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  assign bus.o_alloc_ok   = alloc_ok;
  assign bus.o_alloc_vld  = alloc_vld;
  assign bus.o_alloc_ent0 = ent0;
  assign bus.o_alloc_ent1 = ent1;
  assign bus.o_busy_vec   = busy;
  assign bus.o_free_cnt   = free_cnt;
endmodule

// File: tb/tb_rs_alloc_unit.sv
// Scoreboard bench for rs_alloc_unit with a list-based occupancy model.
module tb_rs_alloc_unit;
  localparam int N   = 4;
  localparam int SEL = 2;
  localparam int W   = 14;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [W-1:0] exp_q[$];
  bit   busy_m[N];

  rs_alloc_unit_if #(.RS_ENT_NUM(N), .RS_ENT_SEL(SEL)) bus ();

  rs_alloc_unit #(.RS_ENT_NUM(N), .RS_ENT_SEL(SEL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.i_dp_req    = 2'b00;
    bus.i_issue_vld = 1'b0;
    bus.i_issue_sel = '0;
    bus.i_flush     = 1'b0;
  endtask

  // Driver: apply one cycle of stimulus, push the model's expectation, advance the model.
  task automatic drive(input logic [1:0] req, input logic iv, input logic [SEL-1:0] sel, input logic fl);
    int         free_list[$];
    int         req_cnt;
    logic       ok;
    logic [1:0] vld;
    logic [SEL-1:0] e0, e1;
    logic [N-1:0]   busy_v;
    bit         prev[N];
    @(posedge clk);
    #1;
    assert (req != 2'b10) else $error("illegal out-of-order request driven");
    bus.i_dp_req    = req;
    bus.i_issue_vld = iv;
    bus.i_issue_sel = sel;
    bus.i_flush     = fl;
    for (int i = 0; i < N; i++) begin
      busy_v[i] = busy_m[i];
      if (!busy_m[i]) free_list.push_back(i);
    end
    req_cnt = int'(req[0]) + int'(req[1]);
    ok  = (req_cnt <= free_list.size()) && !fl;
    vld = {req[1] & ok, req[0] & ok};
    e0  = '0;
    e1  = '0;
    if (vld[0]) e0 = SEL'(free_list[0]);
    if (vld[1]) e1 = SEL'(free_list[1]);
    exp_q.push_back({ok, vld, e0, e1, busy_v, 3'(free_list.size())});
    prev = busy_m;
    if (fl) begin
      for (int i = 0; i < N; i++) busy_m[i] = 1'b0;
    end else begin
      if (vld[0]) busy_m[int'(e0)] = 1'b1;
      if (vld[1]) busy_m[int'(e1)] = 1'b1;
      if (iv && int'(sel) < N && prev[int'(sel)]) busy_m[int'(sel)] = 1'b0;
    end
  endtask

  // Called right after drive(): busy then reflects the edge that consumed the previous cycle.
  task automatic expect_busy(input string name, input logic [N-1:0] b, input logic [2:0] fc);
    check({name, "_busy"}, 32'(bus.o_busy_vec), 32'(b));
    check({name, "_free"}, 32'(bus.o_free_cnt), 32'(fc));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("alloc_ok", 32'(bus.o_alloc_ok), 32'(e[13]));
      check("alloc_vld", 32'(bus.o_alloc_vld), 32'(e[12:11]));
      if (e[11]) check("alloc_ent0", 32'(bus.o_alloc_ent0), 32'(e[10:9]));
      if (e[12]) check("alloc_ent1", 32'(bus.o_alloc_ent1), 32'(e[8:7]));
      check("busy_vec", 32'(bus.o_busy_vec), 32'(e[6:3]));
      check("free_cnt", 32'(bus.o_free_cnt), 32'(e[2:0]));
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < N; i++) busy_m[i] = 1'b0;
    set_idle();
    reset = 1'b1;
    #2;
    check("rst_busy", 32'(bus.o_busy_vec), 32'h0);
    check("rst_free", 32'(bus.o_free_cnt), 32'd4);
    bus.i_dp_req = 2'b11;
    #1;
    check("rst_vld_follows", 32'(bus.o_alloc_vld), 32'h3);
    check("rst_ok", 32'(bus.o_alloc_ok), 32'h1);
    bus.i_dp_req = 2'b00;
    @(negedge clk);
    reset = 1'b0;

    // Issue on empty has no effect
    drive(2'b00, 1'b1, 2'd1, 1'b0);
    // Reset then dual request
    drive(2'b11, 1'b0, 2'd0, 1'b0);
    drive(2'b00, 1'b0, 2'd0, 1'b0);
    expect_busy("d036", 4'b0011, 3'd2);
    // Fill to 0111, then a refused dual request, then a single request takes entry 3
    drive(2'b01, 1'b0, 2'd0, 1'b0);
    drive(2'b11, 1'b0, 2'd0, 1'b0);
    drive(2'b01, 1'b0, 2'd0, 1'b0);
    drive(2'b00, 1'b0, 2'd0, 1'b0);
    expect_busy("d037", 4'b1111, 3'd0);
    // Full: freed entry is not reused in the same cycle
    drive(2'b01, 1'b1, 2'd2, 1'b0);
    drive(2'b01, 1'b0, 2'd0, 1'b0);
    drive(2'b00, 1'b0, 2'd0, 1'b0);
    expect_busy("d038", 4'b1111, 3'd0);
    // Holes at 1 and 3
    drive(2'b00, 1'b1, 2'd1, 1'b0);
    drive(2'b00, 1'b1, 2'd3, 1'b0);
    drive(2'b11, 1'b0, 2'd0, 1'b0);
    drive(2'b00, 1'b0, 2'd0, 1'b0);
    expect_busy("d039", 4'b1111, 3'd0);
    // One free entry: dual refused, single granted
    drive(2'b00, 1'b1, 2'd0, 1'b0);
    drive(2'b11, 1'b0, 2'd0, 1'b0);
    drive(2'b01, 1'b0, 2'd0, 1'b0);
    // Flush overrides a dual request
    drive(2'b11, 1'b1, 2'd1, 1'b1);
    drive(2'b00, 1'b0, 2'd0, 1'b0);
    expect_busy("d040_flush", 4'b0000, 3'd4);
    // Build 1010 then reset between edges
    drive(2'b11, 1'b0, 2'd0, 1'b0);
    drive(2'b11, 1'b0, 2'd0, 1'b0);
    drive(2'b00, 1'b1, 2'd0, 1'b0);
    drive(2'b00, 1'b1, 2'd2, 1'b0);
    @(posedge clk);
    #1;
    set_idle();
    check("pre_rst_busy", 32'(bus.o_busy_vec), 32'b1010);
    #1;
    reset = 1'b1;
    bus.i_dp_req = 2'b11;
    #1;
    check("async_rst_busy", 32'(bus.o_busy_vec), 32'h0);
    check("async_rst_free", 32'(bus.o_free_cnt), 32'd4);
    check("async_rst_ent0", 32'(bus.o_alloc_ent0), 32'd0);
    check("async_rst_ent1", 32'(bus.o_alloc_ent1), 32'd1);
    @(negedge clk);
    bus.i_dp_req = 2'b00;
    reset = 1'b0;
    for (int i = 0; i < N; i++) busy_m[i] = 1'b0;

    // Random dispatch/issue/flush
    for (int n = 0; n < 400; n++) begin
      logic [1:0] r;
      int k;
      k = $urandom_range(0, 2);
      r = (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b11);
      drive(r, 1'($urandom_range(0, 1)), SEL'($urandom_range(0, N - 1)),
            ($urandom_range(0, 19) == 0));
    end

    @(posedge clk);
    #1;
    set_idle();
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
